// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-requester data memory arbiter:
// FSM state encoding, requester indices and the default burst limit.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

    function automatic arb_state_e own_state(input logic idx);
        return (idx == REQ1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store port (0)
// and the loader/debug DMA port (1) with burst-limited round-robin ownership.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [DATA_WIDTH-1:0] mem_ReadData,
    output arb_state_e            dbg_state
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  last_owner_q, last_owner_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic acc0, acc1;
    logic burst_last;

    // Handshake: gnt_i is a ready that depends only on the state register;
    // req_i is a valid held with we/addr/wdata until it meets gnt_i. The cycle
    // where req_i && gnt_i is the accept; reads answer with a one-cycle rvalid_i.

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= REQ1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign burst_last = (burst_cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = own_state(~last_owner_q);
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (burst_last && req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (burst_last && req0) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0          = (state_q == ST_OWN0);
        gnt1          = (state_q == ST_OWN1);
        acc0          = req0 && gnt0;
        acc1          = req1 && gnt1;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        mem_Address   = '0;
        mem_WriteData = '0;
        if (acc0) begin
            mem_MemWrite  = we0;
            mem_MemRead   = ~we0;
            mem_Address   = addr0;
            mem_WriteData = wdata0;
        end else if (acc1) begin
            mem_MemWrite  = we1;
            mem_MemRead   = ~we1;
            mem_Address   = addr1;
            mem_WriteData = wdata1;
        end
    end

    // A lone owner keeps renewing its tenure: the count wraps instead of saturating.
    always_comb begin
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == ST_OWN0) begin
                last_owner_d = REQ0;
            end else if (state_d == ST_OWN1) begin
                last_owner_d = REQ1;
            end
        end else if (acc0 || acc1) begin
            burst_cnt_d = burst_last ? '0 : burst_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rvalid0_d = acc0 && !we0;
        rvalid1_d = acc1 && !we1;
        rdata0_d  = rvalid0_d ? mem_ReadData : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_ReadData : rdata1_q;
    end

    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table, corner-case sequences and a
// randomized run checked against a transaction-level ownership model.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int MB = 4;

    logic clk;
    logic reset;
    logic req0, we0, req1, we1;
    logic [DW-1:0] addr0, wdata0, addr1, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] mem_Address, mem_WriteData, mem_ReadData;
    logic mem_MemWrite, mem_MemRead;
    arb_state_e dbg_state;

    int n_tests;
    int n_fail;

    data_memory_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_ReadData(mem_ReadData), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory ----------------
    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] ref_mem [0:63];
    logic          pl_en;
    logic [5:0]    pl_idx;
    logic [DW-1:0] pl_val;

    assign mem_ReadData = mem[mem_Address[7:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_MemWrite) mem[mem_Address[7:2]] <= mem_WriteData;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pl_en = 1'b1;
        pl_idx = idx[5:0];
        pl_val = v;
        ref_mem[idx] = v;
        next_cycle();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic req0; logic we0; logic [31:0] addr0; logic [31:0] wdata0;
        logic req1; logic we1; logic [31:0] addr1; logic [31:0] wdata1;
        logic e_gnt0; logic e_gnt1; logic e_mw; logic e_mr;
        logic [31:0] e_addr; logic [31:0] e_wd;
        logic e_rv0; logic [31:0] e_rd0;
        logic e_rv1; logic [31:0] e_rd1;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vectors();
        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                    1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
                  vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
            at_neg();
            chk($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].e_gnt0);
            chk($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].e_gnt1);
            chk($sformatf("vec%0d_memwrite", i), mem_MemWrite, vecs[i].e_mw);
            chk($sformatf("vec%0d_memread", i), mem_MemRead, vecs[i].e_mr);
            chk($sformatf("vec%0d_addr", i), mem_Address, vecs[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), mem_WriteData, vecs[i].e_wd);
            chk($sformatf("vec%0d_rvalid0", i), rvalid0, vecs[i].e_rv0);
            chk($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].e_rd0);
            chk($sformatf("vec%0d_rvalid1", i), rvalid1, vecs[i].e_rv1);
            chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e_rd1);
            next_cycle();
        end
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic seq_tie();
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        at_neg();
        chk("tie_idle_gnt0", gnt0, 1'b0);
        chk("tie_idle_gnt1", gnt1, 1'b0);
        next_cycle();
        at_neg();
        chk("tie_first_gnt0", gnt0, 1'b1);
        chk("tie_first_gnt1", gnt1, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        at_neg();
        chk("tie_again_idle", {gnt0, gnt1}, 2'b00);
        next_cycle();
        at_neg();
        chk("tie_second_gnt1", gnt1, 1'b1);
        chk("tie_second_gnt0", gnt0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic seq_burst_limit();
        int  acc0_n = 0;
        int  gap = 0;
        logic seen1 = 1'b0;
        logic started = 1'b0;
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int c = 0; c < 20 && !seen1; c++) begin
            at_neg();
            if (gnt1) seen1 = 1'b1;
            else if (gnt0 && req0) begin
                acc0_n++;
                started = 1'b1;
            end else if (started) gap++;
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("burst_accepts0", acc0_n, 4);
        chk("burst_handover_gnt1", seen1, 1'b1);
        chk("burst_gap_cycles", gap, 0);
        next_cycle();
    endtask

    task automatic seq_uncontested();
        int  acc_n = 0;
        int  lost = 0;
        int  cycles = 0;
        logic started = 1'b0;
        do_reset();
        drive(1, 0, 32'h14, 0, 0, 0, 0, 0);
        for (int c = 0; c < 30 && acc_n < 10; c++) begin
            at_neg();
            cycles++;
            if (gnt1) lost++;
            if (gnt0) begin
                acc_n++;
                started = 1'b1;
            end else if (started) lost++;
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("uncontested_accepts", acc_n, 10);
        chk("uncontested_lost_cycles", lost, 0);
        chk("uncontested_total_cycles", cycles, 11);
        next_cycle();
    endtask

    task automatic seq_reset_mid_burst();
        do_reset();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        next_cycle();
        at_neg();
        chk("rstmid_accept_gnt0", gnt0, 1'b1);
        chk("rstmid_accept_read", mem_MemRead, 1'b1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        at_neg();
        chk("rstmid_rvalid0", rvalid0, 1'b0);
        chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rstmid_gnt0", gnt0, 1'b0);
        chk("rstmid_strobes", {mem_MemWrite, mem_MemRead}, 2'b00);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    // ---------------- reference model ----------------
    // owner: -1 nobody, else requester index. tenure counts accepts modulo MB.
    int m_owner, m_cnt, m_last;
    logic m_rv [2];
    logic [31:0] m_rd [2];

    task automatic m_reset();
        m_owner = -1;
        m_cnt = 0;
        m_last = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
    endtask

    task automatic run_random(input int n_cycles);
        logic r [2];
        logic w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic pend [2];
        logic rst_now;
        int acc, nxt, o;
        logic e_mw, e_mr;
        logic [31:0] e_addr, e_wd;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        reset = 1'b0;
        m_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w[i] = 1'b0; a[i] = '0; d[i] = '0;
        end

        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            at_neg();
            r[0] = req0; r[1] = req1;
            rst_now = reset;
            acc = -1;
            if (m_owner >= 0) begin
                if (r[m_owner]) acc = m_owner;
            end
            e_mw = 1'b0; e_mr = 1'b0; e_addr = '0; e_wd = '0;
            if (acc >= 0) begin
                e_mw = w[acc];
                e_mr = !w[acc];
                e_addr = a[acc];
                e_wd = d[acc];
            end
            chk("rnd_gnt0", gnt0, m_owner == 0);
            chk("rnd_gnt1", gnt1, m_owner == 1);
            chk("rnd_memwrite", mem_MemWrite, e_mw);
            chk("rnd_memread", mem_MemRead, e_mr);
            chk("rnd_addr", mem_Address, e_addr);
            chk("rnd_wdata", mem_WriteData, e_wd);
            chk("rnd_rvalid0", rvalid0, m_rv[0]);
            chk("rnd_rvalid1", rvalid1, m_rv[1]);
            chk("rnd_rdata0", rdata0, m_rd[0]);
            chk("rnd_rdata1", rdata1, m_rd[1]);

            // responses and memory effect of this cycle's accept
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (acc >= 0) begin
                if (w[acc]) ref_mem[a[acc][7:2]] = d[acc];
                else begin
                    m_rd[acc] = ref_mem[a[acc][7:2]];
                    m_rv[acc] = 1'b1;
                end
            end
            // ownership for the next cycle
            if (m_owner < 0) begin
                if (r[0] && r[1]) nxt = 1 - m_last;
                else if (r[0]) nxt = 0;
                else if (r[1]) nxt = 1;
                else nxt = -1;
            end else begin
                o = m_owner;
                if (!r[o]) nxt = r[1 - o] ? 1 - o : -1;
                else if (m_cnt == MB - 1 && r[1 - o]) nxt = 1 - o;
                else nxt = o;
            end
            if (nxt != m_owner) begin
                m_cnt = 0;
                if (nxt >= 0) m_last = nxt;
            end else if (acc >= 0) begin
                m_cnt = (m_cnt + 1) % MB;
            end
            m_owner = nxt;
            if (rst_now) m_reset();

            next_cycle();

            for (int i = 0; i < 2; i++) begin
                if (acc == i || rst_now) pend[i] = 1'b0;
                else if (pend[i] && m_owner != i && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    w[i] = $urandom_range(0, 1) == 1;
                    a[i] = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                    d[i] = $urandom;
                end
            end
            drive(pend[0], w[0], a[0], d[0], pend[1], w[1], a[1], d[1]);
            reset = ($urandom_range(0, 249) == 0);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- main ----------------
    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        pl_en = 1'b0;
        pl_idx = '0;
        pl_val = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) preload(i, 32'(i) * 32'h01010101);
        preload(4, 32'hDEADBEEF);

        at_neg();
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("reset_gnt", {gnt0, gnt1}, 2'b00);
        chk("reset_rvalid", {rvalid0, rvalid1}, 2'b00);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_strobes", {mem_MemWrite, mem_MemRead}, 2'b00);
        next_cycle();
        reset = 1'b0;

        run_vectors();
        seq_tie();
        seq_burst_limit();
        seq_uncontested();
        seq_reset_mid_burst();
        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
